// File: rtl/ser2par_rx_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package ser2par_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ser2par_fifo.sv
// Synchronous show-ahead FIFO: o_dout always presents the head entry (0 when empty).
module ser2par_fifo
  import ser2par_rx_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [DW-1:0]                 i_din,
  input  logic                          i_pop,
  output logic [DW-1:0]                 o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [cnt_width(DEPTH)-1:0]   o_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign o_full  = (cnt == CW'(DEPTH));
  assign o_empty = (cnt == '0);
  assign o_cnt   = cnt;
  assign o_dout  = o_empty ? '0 : mem[rd_ptr];

  // A push into a full FIFO still lands when the head is leaving the same cycle.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are only observable through the empty-gated head.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ser2par_rx.sv
// MSB-first serial word assembler feeding a show-ahead FIFO with sticky error flags.
module ser2par_rx
  import ser2par_rx_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ser_in,
  input  logic                          i_ser_vld,
  input  logic                          i_sof,
  output logic [DW-1:0]                 o_par_out,
  output logic                          o_par_vld,
  input  logic                          i_par_rdy,
  output logic [cnt_width(DEPTH)-1:0]   o_fifo_cnt,
  output logic                          o_ovf,
  output logic                          o_sync_err,
  input  logic                          i_err_clr
);

  localparam int unsigned  CTW  = $clog2(DW);
  localparam logic [CTW-1:0] LAST = CTW'(DW - 1);

  state_t          state, state_n;
  logic [CTW-1:0]  cnt, cnt_n;
  // Only DW-1 bits are kept: the final bit is appended combinationally at push time.
  logic [DW-2:0]   sh, sh_n;
  logic [DW-1:0]   word;
  logic            push;
  logic            pop;
  logic            sync_set;
  logic            ovf_set;
  logic            fifo_full;
  logic            fifo_empty;

  // Assembler state, bit counter, shift register and sticky flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      o_ovf      <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      o_ovf      <= ovf_set  | (o_ovf      & ~i_err_clr);
      o_sync_err <= sync_set | (o_sync_err & ~i_err_clr);
    end
  end

  // Next-state logic: sof always restarts a word, last bit pushes and returns to IDLE.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    push     = 1'b0;
    sync_set = 1'b0;
    word     = {sh, i_ser_in};
    if (i_ser_vld) begin
      case (state)
        IDLE: begin
          if (i_sof) begin
            sh_n    = (DW-1)'(i_ser_in);
            cnt_n   = CTW'(1);
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (i_sof) begin
            sync_set = 1'b1;
            sh_n     = (DW-1)'(i_ser_in);
            cnt_n    = CTW'(1);
          end else begin
            sh_n = word[DW-2:0];
            if (cnt == LAST) begin
              push    = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + CTW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign pop       = ~fifo_empty & i_par_rdy;
  assign o_par_vld = ~fifo_empty;
  assign ovf_set   = push & fifo_full & ~pop;

  ser2par_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_din   (word),
    .i_pop   (pop),
    .o_dout  (o_par_out),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_cnt   (o_fifo_cnt)
  );

endmodule

// File: tb/tb_ser2par_rx.sv
// Self-checking bench for ser2par_rx: directed table, corner sequences, randomized model check.
module tb_ser2par_rx;

  logic       i_clk;
  logic       i_rst;
  logic       i_ser_in;
  logic       i_ser_vld;
  logic       i_sof;
  logic [7:0] o_par_out;
  logic       o_par_vld;
  logic       i_par_rdy;
  logic [2:0] o_fifo_cnt;
  logic       o_ovf;
  logic       o_sync_err;
  logic       i_err_clr;

  int checks = 0;
  int errors = 0;

  ser2par_rx #(
    .DW    (8),
    .DEPTH (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ser_in   (i_ser_in),
    .i_ser_vld  (i_ser_vld),
    .i_sof      (i_sof),
    .o_par_out  (o_par_out),
    .o_par_vld  (o_par_vld),
    .i_par_rdy  (i_par_rdy),
    .o_fifo_cnt (o_fifo_cnt),
    .o_ovf      (o_ovf),
    .o_sync_err (o_sync_err),
    .i_err_clr  (i_err_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] word;
    logic [2:0] exp_cnt;
    logic [7:0] exp_head;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic sof, input logic b, input logic rdy);
    i_ser_vld = 1'b1;
    i_sof     = sof;
    i_ser_in  = b;
    i_par_rdy = rdy;
    step();
    i_ser_vld = 1'b0;
    i_sof     = 1'b0;
    i_par_rdy = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 0; i--) send_bit(i == 7, w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_vld"}, o_par_vld, 1'b1);
    check({name, "_data"}, o_par_out, exp);
    i_par_rdy = 1'b1;
    step();
    i_par_rdy = 1'b0;
  endtask

  task automatic clear_errs();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out"}, o_par_out, 8'h00);
    check({name, "_vld"}, o_par_vld, 1'b0);
    check({name, "_cnt"}, o_fifo_cnt, 3'd0);
    check({name, "_ovf"}, o_ovf, 1'b0);
    check({name, "_serr"}, o_sync_err, 1'b0);
  endtask

  // Word-level reference model state for the random phase.
  logic [7:0] mq [$];
  int         m_bits;
  int         m_val;
  logic       m_ovf;
  logic       m_serr;

  initial begin
    i_rst = 1'b1; i_ser_in = 1'b0; i_ser_vld = 1'b0; i_sof = 1'b0;
    i_par_rdy = 1'b0; i_err_clr = 1'b0;

    vecs[0] = '{8'h01, 3'd1, 8'h01, 1'b0};
    vecs[1] = '{8'h02, 3'd2, 8'h01, 1'b0};
    vecs[2] = '{8'h03, 3'd3, 8'h01, 1'b0};
    vecs[3] = '{8'h04, 3'd4, 8'h01, 1'b0};
    vecs[4] = '{8'h05, 3'd4, 8'h01, 1'b1};

    #1;
    check_all_zero("reset");
    repeat (2) step();
    i_rst = 1'b0;
    step();

    // Single word A5, then pop.
    send_word(8'hA5, 1'b0);
    check("single_vld", o_par_vld, 1'b1);
    check("single_data", o_par_out, 8'hA5);
    check("single_cnt", o_fifo_cnt, 3'd1);
    i_par_rdy = 1'b1; step(); i_par_rdy = 1'b0;
    check("single_empty_vld", o_par_vld, 1'b0);
    check("single_empty_out", o_par_out, 8'h00);
    check("single_empty_cnt", o_fifo_cnt, 3'd0);
    i_par_rdy = 1'b1; step(); i_par_rdy = 1'b0;
    check("rdy_when_empty_cnt", o_fifo_cnt, 3'd0);

    // Gapped bits with a stray unqualified sof mid-word.
    begin
      logic [7:0] w;
      w = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
        send_bit(i == 7, w[i], 1'b0);
        i_ser_in = ~w[i];
        i_sof    = (i == 4);
        step();
        i_sof = 1'b0;
      end
    end
    check("gap_serr", o_sync_err, 1'b0);
    check("gap_cnt", o_fifo_cnt, 3'd1);
    pop_check("gap", 8'h3C);

    // Resync: partial word, then full F0 whose sof coincides with err_clr (set wins).
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    i_err_clr = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    i_err_clr = 1'b0;
    check("resync_set_wins", o_sync_err, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(1'b0, (i >= 4), 1'b0);
    check("resync_cnt", o_fifo_cnt, 3'd1);
    pop_check("resync", 8'hF0);
    check("resync_empty", o_par_vld, 1'b0);
    clear_errs();
    check("errclr_serr", o_sync_err, 1'b0);

    // Overflow table.
    foreach (vecs[k]) begin
      send_word(vecs[k].word, 1'b0);
      check($sformatf("ovf_tbl%0d_cnt", k), o_fifo_cnt, vecs[k].exp_cnt);
      check($sformatf("ovf_tbl%0d_head", k), o_par_out, vecs[k].exp_head);
      check($sformatf("ovf_tbl%0d_ovf", k), o_ovf, vecs[k].exp_ovf);
    end
    for (int k = 1; k <= 4; k++) pop_check($sformatf("ovf_drain%0d", k), 8'(k));
    check("ovf_drained", o_par_vld, 1'b0);
    check("ovf_sticky", o_ovf, 1'b1);
    clear_errs();
    check("errclr_ovf", o_ovf, 1'b0);

    // Full FIFO: last bit of 5th word coincides with a pop.
    for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
    check("fullpp_pre_cnt", o_fifo_cnt, 3'd4);
    send_word(8'h05, 1'b1);
    check("fullpp_ovf", o_ovf, 1'b0);
    check("fullpp_cnt", o_fifo_cnt, 3'd4);
    for (int k = 2; k <= 5; k++) pop_check($sformatf("fullpp_drain%0d", k), 8'(k));
    check("fullpp_empty", o_par_vld, 1'b0);

    // Asynchronous reset mid-word with two entries and a sticky flag set.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("arst_pre_cnt", o_fifo_cnt, 3'd2);
    check("arst_pre_serr", o_sync_err, 1'b1);
    #3 i_rst = 1'b1;
    #1 check_all_zero("arst");
    #2 i_rst = 1'b0;
    step();
    send_word(8'h81, 1'b0);
    check("arst_after_cnt", o_fifo_cnt, 3'd1);
    pop_check("arst_after", 8'h81);
    check("arst_after_empty", o_par_vld, 1'b0);

    // Randomized stream against a word-level model.
    i_rst = 1'b1; step(); i_rst = 1'b0; step();
    mq.delete();
    m_bits = 0; m_val = 0; m_ovf = 1'b0; m_serr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic vld, sof, b, rdy, clr, ovf_set, serr_set, done;
      vld = ($urandom_range(3) != 0);
      sof = ($urandom_range(11) == 0);
      b   = 1'($urandom);
      rdy = ($urandom_range(9) < 4);
      clr = ($urandom_range(29) == 0);
      i_ser_vld = vld; i_sof = sof; i_ser_in = b; i_par_rdy = rdy; i_err_clr = clr;
      ovf_set = 1'b0; serr_set = 1'b0; done = 1'b0;
      if (vld) begin
        if (sof) begin
          if (m_bits > 0) serr_set = 1'b1;
          m_bits = 1; m_val = int'(b);
        end else if (m_bits > 0) begin
          m_val  = m_val * 2 + int'(b);
          m_bits = m_bits + 1;
          if (m_bits == 8) begin done = 1'b1; m_bits = 0; end
        end
      end
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (done) begin
        if (mq.size() < 4) mq.push_back(8'(m_val));
        else ovf_set = 1'b1;
      end
      m_ovf  = ovf_set  | (m_ovf  & ~clr);
      m_serr = serr_set | (m_serr & ~clr);
      step();
      check("rnd_vld", o_par_vld, mq.size() != 0);
      check("rnd_out", o_par_out, (mq.size() != 0) ? mq[0] : 8'h00);
      check("rnd_cnt", o_fifo_cnt, 3'(mq.size()));
      check("rnd_ovf", o_ovf, m_ovf);
      check("rnd_serr", o_sync_err, m_serr);
    end
    i_ser_vld = 1'b0; i_sof = 1'b0; i_par_rdy = 1'b0; i_err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser2par_rx.md
Name: ser2par_rx

Overview:
- Downstream stage of the 8-bit parallel-load shift register.
- Consumes its MSB-first serial stream (the upstream serial output is bit [DW-1]) and reassembles words.
- Buffers words in a small show-ahead FIFO and presents them on a valid/ready parallel interface.
- Flags framing resyncs and FIFO overflow for the consuming logic.

Parameters:
- DW, 8, word width in bits; must equal the upstream shift-register width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_ser_in  input  1  serial data bit, MSB of each word first.
- i_ser_vld  input  1  i_ser_in is sampled this cycle.
- i_sof  input  1  start of word; qualified by i_ser_vld; marks the bit as MSB.
- o_par_out  output  DW  head-of-FIFO word.
- o_par_vld  output  1  FIFO not empty.
- i_par_rdy  input  1  consumer accepts o_par_out when o_par_vld is also high.
- o_fifo_cnt  output  clog2(DEPTH)+1  current FIFO occupancy.
- o_ovf  output  1  sticky: a completed word was dropped because the FIFO was full.
- o_sync_err  output  1  sticky: i_sof arrived while a word was partially assembled.
- i_err_clr  input  1  clears o_ovf and o_sync_err.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state IDLE, bit counter 0, shift register 0, FIFO empty.
  - o_par_out=0, o_par_vld=0, o_fifo_cnt=0, o_ovf=0, o_sync_err=0.
- Cycles with i_ser_vld=0 change nothing in the assembler. i_sof without i_ser_vld is ignored.
- FSM states: IDLE, SHIFT.
  - IDLE:
    - i_ser_vld & i_sof: load i_ser_in into the shift register LSB, cnt=1, go to SHIFT.
    - i_ser_vld without i_sof: bit discarded, stay in IDLE.
  - SHIFT, i_ser_vld & ~i_sof:
    - shift register <= {shift[DW-2:0], i_ser_in}, cnt += 1.
    - When cnt==DW-1 (last bit): push the assembled word {shift[DW-2:0], i_ser_in} to the FIFO, cnt=0, go to IDLE.
  - SHIFT, i_ser_vld & i_sof:
    - discard the partial word, set o_sync_err.
    - the bit becomes the new MSB, cnt=1, stay in SHIFT.
- Back-to-back words: the i_sof bit of the next word may arrive the cycle after the last bit; there is no gap requirement.
- DW=8 timing: the word is complete on the 8th valid bit. It is written to the FIFO on that edge, and o_par_vld rises on the next cycle (latency 1 clock from the last bit's sampling edge).
- FIFO: show-ahead, so o_par_out is always the head entry and is 0 when empty.
  - Pop = o_par_vld & i_par_rdy.
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. A simultaneous push and pop leaves o_fifo_cnt unchanged.
  - Push while full without a pop: the word is dropped, o_ovf is set, and FIFO contents are unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally. The occupancy counter is separate.
- Sticky flags:
  - i_err_clr clears both flags.
  - If a set event and i_err_clr occur in the same cycle, set wins.
- i_par_rdy has no effect while the FIFO is empty.
- Reset mid-word or with FIFO entries: everything is discarded immediately, with no partial output.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, SHIFT).
  - Default DW and DEPTH constants.
  - clog2-based width helper for o_fifo_cnt.
- One sub-module: ser2par_fifo, a synchronous show-ahead FIFO parameterised by DW and DEPTH, with push/pop/full/empty/count.
- The assembler FSM stays in the top module.

Test Plan:
- Single word: sof+bits 1,0,1,0,0,1,0,1 on consecutive cycles -> o_par_vld=1 one cycle after the 8th bit, o_par_out=8'hA5, o_fifo_cnt=1. Then i_par_rdy=1 -> empty next cycle.
- Gapped bits: 8'h3C sent with i_ser_vld low on alternate cycles, i_sof pulsed once without i_ser_vld mid-word -> 8'h3C received, o_sync_err stays 0.
- Resync: sof + 3 bits, then sof + 8 bits of 8'hF0 -> o_sync_err=1, exactly one word 8'hF0 in the FIFO.
- Overflow: i_par_rdy=0, send 5 words 01,02,03,04,05 -> o_fifo_cnt=4, o_ovf=1. Draining yields 01,02,03,04.
- Full push+pop: FIFO full, 5th word completes in the same cycle as a pop -> o_ovf stays 0, o_fifo_cnt stays 4, drain order is 02,03,04,05.
- Async reset: assert i_rst mid-word with 2 FIFO entries -> all outputs 0 immediately, without a clock edge. After release, sof+8'h81 -> 8'h81 is the only word.
